// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer in front of the 32-bit SDRAM controller.
// One access in flight at a time; completion is the rising edge of mem_ready, guarded by a watchdog.
module sdram_arbiter #(
  parameter bit         FIXED_PRIO = 1'b0,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  input  logic [25:0] p0_addr,
  input  logic        p0_we,
  input  logic [3:0]  p0_wstrb,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_done,
  output logic        p0_err,
  input  logic        p1_valid,
  input  logic [25:0] p1_addr,
  input  logic        p1_we,
  input  logic [3:0]  p1_wstrb,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_done,
  output logic        p1_err,
  output logic [25:0] mem_addr,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [3:0]  mem_dqm,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready
);

  // state   | meaning
  // IDLE    | no access in flight, arbitrating between the ports
  // BUSY    | access presented to the controller, waiting for ready to rise
  // RECOVER | access finished, waiting for the controller to drop ready
  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        ready_q;
  logic [7:0]  wd_cnt;
  logic        rise;
  logic        pick;
  logic        sel_we;
  logic [23:0] sel_word;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_wdata;
  logic        unused_addr_lsb;

  assign rise = mem_ready & ~ready_q;
  assign unused_addr_lsb = ^{p0_addr[1:0], p1_addr[1:0]};

  always_comb begin
    if (p0_valid && p1_valid) pick = FIXED_PRIO ? 1'b0 : ~last_grant;
    else                      pick = p1_valid;
    sel_we    = pick ? p1_we         : p0_we;
    sel_word  = pick ? p1_addr[25:2] : p0_addr[25:2];
    sel_wstrb = pick ? p1_wstrb      : p0_wstrb;
    sel_wdata = pick ? p1_wdata      : p0_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wd_cnt     <= 8'd0;
      ready_q    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_dqm    <= '0;
      mem_din    <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
    end else begin
      ready_q <= mem_ready;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_valid || p1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            wd_cnt     <= TIMEOUT;
            mem_addr   <= {sel_word, 2'b00};
            mem_din    <= sel_wdata;
            mem_we     <= sel_we;
            mem_oe     <= ~sel_we;
            mem_dqm    <= sel_we ? ~sel_wstrb : 4'b0000;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // watchdog counts down from TIMEOUT; reaching zero means TIMEOUT cycles without a rise
          if (rise) begin
            if (grant) p1_done <= 1'b1;
            else       p0_done <= 1'b1;
            if (!mem_we) begin
              if (grant) p1_rdata <= mem_dout;
              else       p0_rdata <= mem_dout;
            end
            mem_we  <= 1'b0;
            mem_oe  <= 1'b0;
            mem_dqm <= '0;
            state   <= RECOVER;
          end else if (wd_cnt == 8'd0) begin
            if (grant) begin
              p1_done  <= 1'b1;
              p1_err   <= 1'b1;
              p1_rdata <= '1;
            end else begin
              p0_done  <= 1'b1;
              p0_err   <= 1'b1;
              p0_rdata <= '1;
            end
            mem_we <= 1'b0;
            mem_oe <= 1'b0;
            state  <= RECOVER;
          end else begin
            wd_cnt <= wd_cnt - 8'd1;
          end
        end
        RECOVER: begin
          if (!mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: round-robin instance driven through vector table and corner sequences,
// plus a fixed-priority instance sharing the requester inputs.
module tb_sdram_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic p0_valid, p0_we, p1_valid, p1_we;
  logic [25:0] p0_addr, p1_addr;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_wdata, p1_wdata;

  logic [31:0] a_p0_rdata, a_p1_rdata;
  logic        a_p0_done, a_p1_done, a_p0_err, a_p1_err;
  logic [25:0] a_mem_addr;
  logic        a_mem_we, a_mem_oe, a_mem_ready;
  logic [3:0]  a_mem_dqm;
  logic [31:0] a_mem_din, a_mem_dout;

  logic [31:0] b_unused_p0_rdata, b_unused_p1_rdata;
  logic        b_p0_done, b_p1_done, b_unused_p0_err, b_unused_p1_err;
  logic [25:0] b_mem_addr;
  logic        b_mem_we, b_mem_oe, b_mem_ready;
  logic [3:0]  b_unused_dqm;
  logic [31:0] b_unused_din, b_mem_dout;

  always #5 clk = ~clk;

  sdram_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(8'd8)) dut_a (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wstrb(p0_wstrb), .p0_wdata(p0_wdata),
    .p0_rdata(a_p0_rdata), .p0_done(a_p0_done), .p0_err(a_p0_err),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wstrb(p1_wstrb), .p1_wdata(p1_wdata),
    .p1_rdata(a_p1_rdata), .p1_done(a_p1_done), .p1_err(a_p1_err),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_oe(a_mem_oe), .mem_dqm(a_mem_dqm),
    .mem_din(a_mem_din), .mem_dout(a_mem_dout), .mem_ready(a_mem_ready)
  );

  sdram_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(8'd8)) dut_b (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wstrb(p0_wstrb), .p0_wdata(p0_wdata),
    .p0_rdata(b_unused_p0_rdata), .p0_done(b_p0_done), .p0_err(b_unused_p0_err),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wstrb(p1_wstrb), .p1_wdata(p1_wdata),
    .p1_rdata(b_unused_p1_rdata), .p1_done(b_p1_done), .p1_err(b_unused_p1_err),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_oe(b_mem_oe), .mem_dqm(b_unused_dqm),
    .mem_din(b_unused_din), .mem_dout(b_mem_dout), .mem_ready(b_mem_ready)
  );

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [25:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [25:0] exp_addr;
    logic [3:0]  exp_dqm;
  } vec_t;

  exp_t        sb[$];
  bit          b_log[$];
  vec_t        vecs[7];
  logic [31:0] last_rd[2];
  int total = 0;
  int bad = 0;
  int resp_delay = 1;
  int resp_len = 2;
  int a_cnt = 0, a_left = 0, b_cnt = 0, b_left = 0;

  function automatic logic [31:0] mem_data(input logic [25:0] a);
    return (a == 26'h0000120) ? 32'hCAFEBABE : {6'h15, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input bit we, input logic [25:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    if (p) begin
      p1_valid = v; p1_we = we; p1_addr = a; p1_wstrb = s; p1_wdata = d;
    end else begin
      p0_valid = v; p0_we = we; p0_addr = a; p0_wstrb = s; p0_wdata = d;
    end
  endtask

  task automatic expect_done(input bit p, input bit we, input logic [25:0] a, input bit to);
    exp_t e;
    e.port  = p;
    e.err   = to;
    e.rdata = to ? 32'hFFFF_FFFF : (we ? last_rd[p] : mem_data(a));
    last_rd[p] = e.rdata;
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit p, input string nm);
    int n;
    n = 0;
    while (!(p ? a_p1_done : a_p0_done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 64'(n < 60), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (a_mem_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_fall", 64'(n < 20), 64'd1);
    @(negedge clk);
  endtask

  // controller models: raise ready resp_delay cycles after a strobe, hold it resp_len cycles
  always @(negedge clk) begin
    if (reset) begin
      a_cnt = 0; a_left = 0;
    end else if (a_left > 0) begin
      a_left--;
    end else if ((a_mem_we || a_mem_oe) && resp_len > 0) begin
      a_cnt++;
      if (a_cnt > resp_delay) begin
        a_left = resp_len; a_cnt = 0; a_mem_dout = mem_data(a_mem_addr);
      end
    end else begin
      a_cnt = 0;
    end
    a_mem_ready = (a_left > 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      b_cnt = 0; b_left = 0;
    end else if (b_left > 0) begin
      b_left--;
    end else if ((b_mem_we || b_mem_oe) && resp_len > 0) begin
      b_cnt++;
      if (b_cnt > resp_delay) begin
        b_left = resp_len; b_cnt = 0; b_mem_dout = mem_data(b_mem_addr);
      end
    end else begin
      b_cnt = 0;
    end
    b_mem_ready = (b_left > 0);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if ((a_p0_err && !a_p0_done) || (a_p1_err && !a_p1_done))
        chk("err_without_done", {a_p0_err, a_p1_err}, 64'd0);
      if (a_p0_done || a_p1_done) begin
        exp_t e;
        chk("single_done", {a_p0_done, a_p1_done}, a_p1_done ? 64'd1 : 64'd2);
        if (sb.size() == 0) begin
          chk("unexpected_done", {a_p0_done, a_p1_done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_port", a_p1_done, e.port);
          chk("done_rdata", a_p1_done ? a_p1_rdata : a_p0_rdata, e.rdata);
          chk("done_err", a_p1_done ? a_p1_err : a_p0_err, e.err);
        end
      end
      if (b_p0_done || b_p1_done) b_log.push_back(b_p1_done);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    int n, k, ov;
    vecs[0] = '{1'b0, 1'b0, 26'h0000123, 4'hF, 32'hDEADBEEF, 26'h0000120, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 26'h1555556, 4'hF, 32'h00000000, 26'h1555554, 4'h0};
    vecs[2] = '{1'b1, 1'b1, 26'h3FFFFFF, 4'h5, 32'h11223344, 26'h3FFFFFC, 4'hA};
    vecs[3] = '{1'b0, 1'b1, 26'h2000007, 4'hF, 32'hA5A55A5A, 26'h2000004, 4'h0};
    vecs[4] = '{1'b0, 1'b1, 26'h0000002, 4'h0, 32'h00000000, 26'h0000000, 4'hF};
    vecs[5] = '{1'b1, 1'b1, 26'h0000FFF, 4'h8, 32'h89ABCDEF, 26'h0000FFC, 4'h7};
    vecs[6] = '{1'b0, 1'b0, 26'h0000004, 4'h5, 32'h00000000, 26'h0000004, 4'h0};
    last_rd[0] = '0;
    last_rd[1] = '0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_rdata", {a_p0_rdata, a_p1_rdata}, 64'd0);
    chk("rst_ctl", {a_mem_addr, a_mem_we, a_mem_oe, a_mem_dqm, a_p0_done, a_p1_done, a_p0_err, a_p1_err}, 64'd0);
    chk("rst_din", a_mem_din, 64'd0);

    // both ports hammering: round-robin alternates from port 0, fixed priority starves port 1
    b_log.delete();
    drive(1'b0, 1'b1, 1'b0, 26'h40, 4'hF, '0);
    drive(1'b1, 1'b1, 1'b0, 26'h80, 4'hF, '0);
    for (int i = 0; i < 4; i++) expect_done(i[0], 1'b0, i[0] ? 26'h80 : 26'h40, 1'b0);
    n = 0; k = 0;
    while (n < 4 && k < 200) begin
      @(negedge clk);
      k++;
      if (a_p0_done || a_p1_done) n++;
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    chk("rr_done_count", n, 4);
    wait_idle();
    chk("fp_count", b_log.size(), 4);
    foreach (b_log[i]) chk($sformatf("fp_grant%0d", i), b_log[i], 0);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata);
      expect_done(vecs[i].port, vecs[i].we, vecs[i].exp_addr, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_mem", i), {a_mem_addr, a_mem_we, a_mem_oe, a_mem_dqm, a_mem_din},
          {vecs[i].exp_addr, vecs[i].we, ~vecs[i].we, vecs[i].exp_dqm, vecs[i].wdata});
      wait_done(vecs[i].port, $sformatf("vec%0d", i));
      if (vecs[i].port) p1_valid = 1'b0;
      else              p0_valid = 1'b0;
      chk($sformatf("vec%0d_strobe_drop", i), {a_mem_we, a_mem_oe}, 64'd0);
      wait_idle();
    end

    // extended ready with an immediate re-request
    resp_len = 3;
    drive(1'b0, 1'b1, 1'b0, 26'h200, 4'hF, '0);
    expect_done(1'b0, 1'b0, 26'h200, 1'b0);
    wait_done(1'b0, "ext1");
    drive(1'b0, 1'b1, 1'b0, 26'h300, 4'hF, '0);
    expect_done(1'b0, 1'b0, 26'h300, 1'b0);
    ov = 0; k = 0;
    while (a_mem_ready && k < 20) begin
      if (a_mem_oe || a_mem_we) ov++;
      @(negedge clk);
      k++;
    end
    chk("ext_no_overlap", ov, 0);
    k = 0;
    while (!a_mem_oe && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ext_reissue", {a_mem_oe, a_mem_ready, a_mem_addr}, {1'b1, 1'b0, 26'h300});
    wait_done(1'b0, "ext2");
    p0_valid = 1'b0;
    wait_idle();
    resp_len = 2;

    // controller never answers
    resp_len = 0;
    drive(1'b0, 1'b1, 1'b0, 26'h400, 4'hF, '0);
    expect_done(1'b0, 1'b0, 26'h400, 1'b1);
    @(negedge clk);
    k = 0;
    while (!a_p0_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", k, 9);
    p0_valid = 1'b0;
    chk("timeout_strobe_drop", {a_mem_we, a_mem_oe}, 64'd0);
    wait_idle();

    // reset while port 1 read is in flight
    drive(1'b1, 1'b1, 1'b0, 26'h500, 4'hF, '0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    p1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    resp_len = 2;
    last_rd[0] = '0;
    last_rd[1] = '0;
    chk("midrst_rdata", {a_p0_rdata, a_p1_rdata}, 64'd0);
    chk("midrst_ctl", {a_mem_addr, a_mem_we, a_mem_oe, a_mem_dqm, a_p0_done, a_p1_done, a_p0_err, a_p1_err}, 64'd0);
    chk("midrst_din", a_mem_din, 64'd0);
    repeat (12) @(negedge clk);

    drive(1'b0, 1'b1, 1'b0, 26'h600, 4'hF, '0);
    drive(1'b1, 1'b1, 1'b1, 26'h700, 4'h3, 32'h0BADF00D);
    expect_done(1'b0, 1'b0, 26'h600, 1'b0);
    expect_done(1'b1, 1'b1, 26'h700, 1'b0);
    n = 0; k = 0;
    while (n < 2 && k < 100) begin
      @(negedge clk);
      k++;
      if (a_p0_done) begin p0_valid = 1'b0; n++; end
      if (a_p1_done) begin p1_valid = 1'b0; n++; end
    end
    chk("post_rst_done_count", n, 2);
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 32-bit SDRAM controller.
- Port 0 serves the CPU load/store unit. Port 1 serves a DMA/video fetcher.
- Latches one request at a time, holds the controller's request lines stable for the whole slot, and detects completion on the rising edge of the controller's ready.
- Returns read data and a one-cycle done pulse to the winning port.
- A watchdog aborts transfers the controller never completes.

Parameters:
- FIXED_PRIO, 0, 1 = port 0 always wins a simultaneous request; 0 = round-robin.
- TIMEOUT, 8'd255, number of BUSY cycles without a ready rising edge before abort.

Ports:
- clk  input  1  system clock, same clock as the SDRAM controller.
- reset  input  1  synchronous, active-high reset.
- p0_valid  input  1  port 0 request; held high until p0_done.
- p0_addr  input  26  port 0 byte address.
- p0_we  input  1  port 0 write (1) / read (0).
- p0_wstrb  input  4  port 0 byte-write enables, bit n = byte n.
- p0_wdata  input  32  port 0 write data.
- p0_rdata  output  32  port 0 read data, valid when p0_done is high.
- p0_done  output  1  one-cycle completion pulse for port 0.
- p0_err  output  1  one-cycle pulse coincident with p0_done on timeout.
- p1_*  same set as p0_*  port 1 equivalents.
- mem_addr  output  26  to controller addr; bits [1:0] are forced to 0.
- mem_we  output  1  to controller we.
- mem_oe  output  1  to controller oeA.
- mem_dqm  output  4  to controller dqm; 1 = byte masked.
- mem_din  output  32  to controller din.
- mem_dout  input  32  from controller dout.
- mem_ready  input  1  from controller ready; high for 2+ cycles per completed access.

Behaviour:
Reset values:
- All outputs 0 (mem_we, mem_oe, mem_dqm, mem_addr, mem_din, pN_rdata, pN_done, pN_err).
- State = IDLE.
- last_grant = 1, so port 0 wins first under round-robin.
- Watchdog counter = 0.
- ready_q = 0.

Register ready_q <= mem_ready every cycle. Define rise = mem_ready & ~ready_q.

IDLE:
- No valid: stay.
- One valid: grant that port.
- Both valid:
  - FIXED_PRIO=1: grant port 0.
  - FIXED_PRIO=0: grant the port != last_grant.
- On grant, register the port's fields:
  - mem_addr = {addr[25:2], 2'b00}.
  - mem_din = wdata.
  - mem_we = we, mem_oe = ~we.
  - mem_dqm = we ? ~wstrb : 4'b0000.
- Set last_grant = granted port, clear watchdog, go to BUSY.
- mem_* lines become valid the cycle after valid is first seen.

BUSY:
- mem_* lines are held constant; requester inputs are ignored.
- If valid drops mid-transfer, the access still completes and done still pulses.
- Watchdog increments every cycle.
- On rise:
  - Read: granted pN_rdata <= mem_dout.
  - Write: pN_rdata is unchanged.
  - pN_done = 1 for one cycle.
  - mem_we = mem_oe = 0, mem_dqm = 0.
  - Go to RECOVER.
- Else if watchdog == TIMEOUT:
  - pN_done = 1 and pN_err = 1 for one cycle.
  - rdata = 32'hFFFF_FFFF.
  - Drop mem_we/mem_oe, go to RECOVER.
- rise and timeout in the same cycle: rise wins, err = 0.

RECOVER:
- Stay while mem_ready == 1.
- Go to IDLE when mem_ready == 0. This prevents the controller's extended ready from completing the next request.
- Zero-cycle RECOVER is allowed: if mem_ready is already 0, go to IDLE next cycle.

General rules:
- A done pulse never occurs for a port that is not granted.
- Both done pulses never occur in the same cycle.
- A requester may present its next request in the cycle after its done pulse.
- Under round-robin with both ports continuously valid, grants strictly alternate.
- reset asserted in any state returns to IDLE with reset values on the next edge. Any in-flight access is abandoned with no done pulse.

Test Plan:
- Single read: p0_valid, addr 26'h0000123, we 0 -> mem_addr 26'h0000120, mem_oe 1; controller returns 32'hCAFEBABE on ready rise -> p0_rdata 32'hCAFEBABE, p0_done 1 for exactly 1 cycle, mem_oe 0 the next cycle.
- Write strobes: p1 write, wstrb 4'b0101, wdata 32'h11223344 -> mem_we 1, mem_dqm 4'b1010, mem_din 32'h11223344; p1_done on ready rise; p1_rdata unchanged.
- Contention, round-robin: both ports valid continuously for 4 transfers -> grant order 0,1,0,1. With FIXED_PRIO=1 -> 0,0,0,0 while p0 stays valid.
- Extended ready: mem_ready held high 3 cycles and p0 immediately re-requests -> exactly one p0_done; the new access is issued only after mem_ready returns to 0.
- Timeout: TIMEOUT=8, mem_ready stuck 0 -> p0_done and p0_err pulse 9 cycles after BUSY entry, rdata 32'hFFFFFFFF, then IDLE.
- Reset mid-BUSY: assert reset for 1 cycle during a port 1 read -> all outputs 0, no p1_done; a following p0 request is granted first.
